// File: rtl/i2cs_arb_pkg.sv
// Shared types for the I2C-slave register-bank arbiter.
// States and requester ids used by i2cs_reg_arbiter and i2cs_arb_pick.
package i2cs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic REQ_APB = 1'b0;
  localparam logic REQ_I2C = 1'b1;

endpackage

// File: rtl/i2cs_arb_pick.sv
// Winner select between the APB and I2C requesters.
// Define I2CS_ARB_FIXED_PRIO_EN to make I2C win every tie.
module i2cs_arb_pick
  import i2cs_arb_pkg::*;
(
  input  logic apb_req,
  input  logic i2c_req,
  input  logic last_winner,
  output logic winner
);

`ifdef I2CS_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_winner;

  always_comb begin
    winner = REQ_APB;
    unique case (1'b1)
      i2c_req: winner = REQ_I2C;
      default: winner = REQ_APB;
    endcase
  end
`else
  always_comb begin
    winner = REQ_APB;
    unique case (1'b1)
      (apb_req && i2c_req):  winner = ~last_winner;
      (!apb_req && i2c_req): winner = REQ_I2C;
      default:               winner = REQ_APB;
    endcase
  end
`endif

endmodule

// File: rtl/i2cs_reg_arbiter.sv
// Arbitrates APB and I2C accesses onto the single-port register bank.
// I2CS_ARB_FIXED_PRIO_EN selects fixed I2C priority instead of round-robin.
module i2cs_reg_arbiter
  import i2cs_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              apb_pclk_i,
  input  logic              apb_preset_i,
  input  logic              apb_req_i,
  input  logic              apb_we_i,
  input  logic [ADDR_W-1:0] apb_addr_i,
  input  logic [DATA_W-1:0] apb_wdata_i,
  output logic              apb_gnt_o,
  output logic              apb_rvalid_o,
  output logic [DATA_W-1:0] apb_rdata_o,
  input  logic              i2c_req_i,
  input  logic              i2c_we_i,
  input  logic [ADDR_W-1:0] i2c_addr_i,
  input  logic [DATA_W-1:0] i2c_wdata_i,
  output logic              i2c_gnt_o,
  output logic              i2c_rvalid_o,
  output logic [DATA_W-1:0] i2c_rdata_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              arb_busy_o
);

  arb_state_t state, state_nx;
  logic       winner_q;
  logic       we_q;
  logic       last_q;
  logic       pick;
  logic       any_req;

  assign any_req    = apb_req_i | i2c_req_i;
  assign arb_busy_o = (state != IDLE);

  i2cs_arb_pick u_pick (
    .apb_req     (apb_req_i),
    .i2c_req     (i2c_req_i),
    .last_winner (last_q),
    .winner      (pick)
  );

  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      state       <= IDLE;
      winner_q    <= REQ_APB;
      we_q        <= 1'b0;
      last_q      <= REQ_I2C;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      apb_rdata_o <= '0;
      i2c_rdata_o <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        winner_q    <= pick;
        last_q      <= pick;
        we_q        <= pick ? i2c_we_i : apb_we_i;
        reg_addr_o  <= pick ? i2c_addr_i : apb_addr_i;
        reg_wdata_o <= pick ? i2c_wdata_i : apb_wdata_i;
      end
      // Bank data is combinational from reg_addr_o, so grab it as ISSUE ends
      if (state == ISSUE && !we_q) begin
        if (winner_q == REQ_I2C) i2c_rdata_o <= reg_rdata_i;
        else                     apb_rdata_o <= reg_rdata_i;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    apb_gnt_o    = 1'b0;
    i2c_gnt_o    = 1'b0;
    apb_rvalid_o = 1'b0;
    i2c_rvalid_o = 1'b0;
    reg_we_o     = 1'b0;
    reg_re_o     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        apb_gnt_o = (winner_q == REQ_APB);
        i2c_gnt_o = (winner_q == REQ_I2C);
        reg_we_o  = we_q;
        reg_re_o  = !we_q;
        state_nx  = we_q ? IDLE : RESP;
      end
      RESP: begin
        apb_rvalid_o = (winner_q == REQ_APB);
        i2c_rvalid_o = (winner_q == REQ_I2C);
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2cs_reg_arbiter.sv
// Directed plus randomized bench for i2cs_reg_arbiter.
// Reference: a plain register-bank array and requester-level grant order.
module tb_i2cs_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        apb_req = 1'b0, apb_we = 1'b0;
  logic [7:0]  apb_addr = '0;
  logic [31:0] apb_wdata = '0;
  logic        i2c_req = 1'b0, i2c_we = 1'b0;
  logic [7:0]  i2c_addr = '0;
  logic [31:0] i2c_wdata = '0;
  logic        apb_gnt, i2c_gnt, apb_rvalid, i2c_rvalid;
  logic [31:0] apb_rdata, i2c_rdata;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy;

  logic [31:0] bank [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata [2];
  bit          last_g;
  int          nerr = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  assign reg_rdata = bank[reg_addr];
  always @(posedge clk) if (reg_we) bank[reg_addr] = reg_wdata;

  i2cs_reg_arbiter dut (
    .apb_pclk_i   (clk),
    .apb_preset_i (rst),
    .apb_req_i    (apb_req),
    .apb_we_i     (apb_we),
    .apb_addr_i   (apb_addr),
    .apb_wdata_i  (apb_wdata),
    .apb_gnt_o    (apb_gnt),
    .apb_rvalid_o (apb_rvalid),
    .apb_rdata_o  (apb_rdata),
    .i2c_req_i    (i2c_req),
    .i2c_we_i     (i2c_we),
    .i2c_addr_i   (i2c_addr),
    .i2c_wdata_i  (i2c_wdata),
    .i2c_gnt_o    (i2c_gnt),
    .i2c_rvalid_o (i2c_rvalid),
    .i2c_rdata_o  (i2c_rdata),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_we_o     (reg_we),
    .reg_re_o     (reg_re),
    .reg_rdata_i  (reg_rdata),
    .arb_busy_o   (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit who, input bit v, input bit we,
                         input logic [7:0] a, input logic [31:0] d);
    if (who) begin
      i2c_req = v; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end else begin
      apb_req = v; apb_we = we; apb_addr = a; apb_wdata = d;
    end
  endtask

  function automatic bit exp_pick(bit pa, bit pi);
`ifdef I2CS_ARB_FIXED_PRIO_EN
    if (pa && pi) return 1'b1;
`else
    if (pa && pi) return !last_g;
`endif
    return pi;
  endfunction

  task automatic chk_rdata();
    chk("apb_rdata", apb_rdata, exp_rdata[0]);
    chk("i2c_rdata", i2c_rdata, exp_rdata[1]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt"}, {apb_gnt, i2c_gnt}, 2'b00);
    chk({tag, "_rvalid"}, {apb_rvalid, i2c_rvalid}, 2'b00);
    chk({tag, "_strobe"}, {reg_we, reg_re}, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_addr"}, reg_addr, 8'h00);
    chk({tag, "_wdata"}, reg_wdata, 32'h0);
    chk({tag, "_rdata"}, {apb_rdata, i2c_rdata}, 64'h0);
  endtask

  // One uncontended access with exact latency checks
  task automatic single(input bit who, input bit we, input logic [7:0] a,
                        input logic [31:0] d);
    set_req(who, 1'b1, we, a, d);
    step();
    chk("s_gnt", {apb_gnt, i2c_gnt}, who ? 2'b01 : 2'b10);
    chk("s_we", reg_we, we);
    chk("s_re", reg_re, !we);
    chk("s_addr", reg_addr, a);
    chk("s_busy", busy, 1'b1);
    if (we) chk("s_wdata", reg_wdata, d);
    set_req(who, 1'b0, we, a, d);
    last_g = who;
    step();
    if (we) begin
      ref_mem[a] = d;
      chk("s_wr_norv", {apb_rvalid, i2c_rvalid}, 2'b00);
      chk("s_wr_idle", busy, 1'b0);
    end else begin
      exp_rdata[who] = ref_mem[a];
      chk("s_rvalid", {apb_rvalid, i2c_rvalid}, who ? 2'b01 : 2'b10);
      chk_rdata();
      step();
      chk("s_rd_idle", busy, 1'b0);
    end
  endtask

  // Both requesters issue a stream; grant order is checked against exp_pick
  task automatic burst(input int na, input int ni, input bit allow_rd);
    int          left [2];
    logic [7:0]  ad [2];
    logic [31:0] dd [2];
    bit          ww [2];
    bit          pend;
    bit          pwho;
    bit          g;
    logic [31:0] pdat;
    int          cyc;
    left[0] = na;
    left[1] = ni;
    pend = 1'b0;
    pwho = 1'b0;
    pdat = '0;
    cyc = 0;
    for (int r = 0; r < 2; r++) begin
      ad[r] = 8'($urandom_range(0, 255));
      dd[r] = $urandom;
      ww[r] = allow_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_req(r[0], left[r] > 0, ww[r], ad[r], dd[r]);
    end
    while ((left[0] > 0 || left[1] > 0 || pend) && cyc < 400) begin
      step();
      cyc++;
      chk("b_rvalid", {apb_rvalid, i2c_rvalid},
          {pend && !pwho, pend && pwho});
      if (pend) begin
        exp_rdata[pwho] = pdat;
        chk_rdata();
        pend = 1'b0;
      end
      chk("b_gnt_excl", apb_gnt & i2c_gnt, 1'b0);
      if (apb_gnt || i2c_gnt) begin
        g = i2c_gnt;
        chk("b_winner", g, exp_pick(left[0] > 0, left[1] > 0));
        chk("b_addr", reg_addr, ad[g]);
        chk("b_strobe", {reg_we, reg_re}, {ww[g], !ww[g]});
        if (ww[g]) begin
          chk("b_wdata", reg_wdata, dd[g]);
          ref_mem[ad[g]] = dd[g];
        end else begin
          pend = 1'b1;
          pwho = g;
          pdat = ref_mem[ad[g]];
        end
        last_g = g;
        left[g]--;
        ad[g] = 8'($urandom_range(0, 255));
        dd[g] = $urandom;
        ww[g] = allow_rd ? 1'($urandom_range(0, 1)) : 1'b1;
        set_req(g, left[g] > 0, ww[g], ad[g], dd[g]);
      end
    end
    if (cyc >= 400) chk("b_timeout", 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
  endtask

  initial begin
    int gcount;
    for (int i = 0; i < 256; i++) begin
      bank[i]    = {24'h0, 8'(i) ^ 8'h5E};
      ref_mem[i] = {24'h0, 8'(i) ^ 8'h5E};
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_g = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("rst");

    // Continuous contention: alternating (or I2C-first when fixed priority)
    burst(6, 6, 1'b0);

    single(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    chk("bank_10", bank[8'h10], 32'hDEADBEEF);
    single(1'b1, 1'b0, 8'h04, 32'h0);
    chk("i2c_rd_5a", i2c_rdata, 32'h0000005A);

    // I2C request raised while an APB read is in RESP
    set_req(1'b0, 1'b1, 1'b0, 8'h22, 32'h0);
    step();
    chk("r_apb_gnt", apb_gnt, 1'b1);
    set_req(1'b0, 1'b0, 1'b0, 8'h22, 32'h0);
    last_g = 1'b0;
    step();
    chk("r_apb_rv", apb_rvalid, 1'b1);
    exp_rdata[0] = ref_mem[8'h22];
    set_req(1'b1, 1'b1, 1'b0, 8'h33, 32'h0);
    step();
    chk("r_idle_gnt", {apb_gnt, i2c_gnt, busy}, 3'b000);
    step();
    chk("r_i2c_gnt", {apb_gnt, i2c_gnt}, 2'b01);
    chk("r_i2c_addr", reg_addr, 8'h33);
    set_req(1'b1, 1'b0, 1'b0, 8'h33, 32'h0);
    last_g = 1'b1;
    step();
    chk("r_i2c_rv", i2c_rvalid, 1'b1);
    exp_rdata[1] = ref_mem[8'h33];
    chk_rdata();
    step();

    // Reset during ISSUE of an APB read
    set_req(1'b0, 1'b1, 1'b0, 8'h55, 32'h0);
    step();
    chk("x_gnt", apb_gnt, 1'b1);
    #2;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h55, 32'h0);
    step();
    rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_g = 1'b1;
    chk_reset_state("x");
    step();
    chk("x_norv", {apb_rvalid, i2c_rvalid, apb_gnt, i2c_gnt}, 4'h0);
    single(1'b0, 1'b0, 8'h55, 32'h0);

    // Req held one cycle past a write gnt
    set_req(1'b0, 1'b1, 1'b1, 8'h44, 32'hCAFE0123);
    step();
    chk("d_gnt", apb_gnt, 1'b1);
    ref_mem[8'h44] = 32'hCAFE0123;
    last_g = 1'b0;
    step();
    chk("d_idle", {apb_gnt, busy}, 2'b00);
    set_req(1'b0, 1'b0, 1'b1, 8'h44, 32'hCAFE0123);
    gcount = 0;
    repeat (4) begin
      step();
      gcount += int'(apb_gnt);
    end
    chk("d_no_regrant", gcount, 0);
    chk("d_bank", bank[8'h44], 32'hCAFE0123);

    // Randomized traffic
    repeat (8) begin
      single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom);
    end
    repeat (6) begin
      burst($urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
    end
    for (int i = 0; i < 256; i += 17) chk("final_bank", bank[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
